// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port data memory (1-cycle synchronous read) between the
// CPU MEM stage (port 0) and the debug/loader port (port 1). The CPU wins by
// default. After STARVE_MAX consecutive denied debug cycles, the debug port
// takes one slot. Read data goes back to the port that issued the read, one
// cycle after acceptance.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cpu_req/we/addr/...   CPU request fields (held stable while stalled)
//   cpu_gnt               CPU request accepted this cycle (combinational)
//   cpu_stall             cpu_req & ~cpu_gnt, to the pipeline hazard logic
//   cpu_rvalid/rdata      CPU read return
//   dbg_req/we/addr/...   debug request fields
//   dbg_gnt               debug request accepted this cycle (combinational)
//   dbg_rvalid/rdata      debug read return
//   mem_read/write/...    request to the data memory from the granted port
//   mem_rdata             memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_func3,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned     CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Request payload carried from a port to the memory.
  typedef struct packed {
    logic                  we;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            func3;
  } port_req_t;

  port_req_t cpu_req_s;
  port_req_t dbg_req_s;
  port_req_t mem_req_s;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rd_own_cpu_q, rd_own_cpu_d;
  logic             rd_own_dbg_q, rd_own_dbg_d;
  logic             dbg_pri;

  assign cpu_req_s = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, func3: cpu_func3};
  assign dbg_req_s = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, func3: dbg_func3};

  // Debug gets priority only once it has been denied STARVE_MAX cycles in a row.
  assign dbg_pri = (starve_q == STARVE_LIM);

  // Grant selection; nothing is granted while reset is high.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (dbg_pri) begin
        dbg_gnt = dbg_req;
        cpu_gnt = cpu_req & ~dbg_req;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory mux: only the winner reaches memory; idle drives all zeros.
  always_comb begin
    mem_req_s = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (cpu_gnt) begin
      mem_req_s = cpu_req_s;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (dbg_gnt) begin
      mem_req_s = dbg_req_s;
      mem_read  = ~dbg_we;
      mem_write = dbg_we;
    end
  end

  assign mem_addr  = mem_req_s.addr;
  assign mem_wdata = mem_req_s.wdata;
  assign mem_func3 = mem_req_s.func3;

  // Starvation counter: counts consecutive denied debug cycles, saturating.
  // A withdrawn or granted debug request restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Read ownership: remembers which port issued the read now in flight.
  always_comb begin
    rd_own_cpu_d = cpu_gnt & ~cpu_we;
    rd_own_dbg_d = dbg_gnt & ~dbg_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= '0;
      rd_own_cpu_q <= 1'b0;
      rd_own_dbg_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      rd_own_cpu_q <= rd_own_cpu_d;
      rd_own_dbg_q <= rd_own_dbg_d;
    end
  end

  // A read accepted just before reset must not return while reset is high,
  // so the owner flags are qualified with reset.
  assign cpu_rvalid = rd_own_cpu_q & ~reset;
  assign dbg_rvalid = rd_own_dbg_q & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a behavioural data memory.
// Expected grants come from the test plan; expected read returns are pushed
// to a scoreboard when a read is accepted and popped one cycle later.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_func3;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [2:0]    dbg_func3;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_func3(dbg_func3), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  // Background contents of never-written words.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    if (a == 9'h010) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 | (32'(a) * 32'h0001_0001);
  endfunction

  // Behavioural data memory: synchronous write, 1-cycle read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [(1<<AW)-1:0] wr_vld;
  logic mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      wr_vld <= '0;
    end else if (mem_write) begin
      mem[mem_addr]    <= mem_wdata;
      wr_vld[mem_addr] <= 1'b1;
    end
    if (mem_read) mem_rdata <= wr_vld[mem_addr] ? mem[mem_addr] : pattern(mem_addr);
  end

  // Expected memory contents, maintained from the writes the bench expects.
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pattern(a);
  endfunction

  typedef struct {
    logic          port;   // 0 = CPU, 1 = debug
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [2:0] f3);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_func3 = f3;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [2:0] f3);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_func3 = f3;
  endtask

  // Pops the read expected back this cycle (if any) and checks both return ports.
  task automatic sb_check(input string tag);
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(!e.port));
      check({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(e.port));
      check({tag, ".cpu_rdata"}, cpu_rdata, e.port ? 32'h0 : e.data);
      check({tag, ".dbg_rdata"}, dbg_rdata, e.port ? e.data : 32'h0);
    end else begin
      check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
      check({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
      check({tag, ".cpu_rdata"}, cpu_rdata, 32'h0);
      check({tag, ".dbg_rdata"}, dbg_rdata, 32'h0);
    end
  endtask

  // One clock cycle: inputs are already driven; checks at the falling edge,
  // then advances to just after the next rising edge.
  task automatic cyc(input logic ec, input logic ed, input logic push, input string tag);
    logic          g, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [2:0]    f3;
    #4;
    sb_check(tag);
    g  = ec | ed;
    we = ec ? cpu_we : (ed ? dbg_we : 1'b0);
    a  = ec ? cpu_addr : (ed ? dbg_addr : '0);
    wd = ec ? cpu_wdata : (ed ? dbg_wdata : '0);
    f3 = ec ? cpu_func3 : (ed ? dbg_func3 : 3'b0);
    check({tag, ".cpu_gnt"},   32'(cpu_gnt),   32'(ec));
    check({tag, ".dbg_gnt"},   32'(dbg_gnt),   32'(ed));
    check({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(cpu_req & ~ec));
    check({tag, ".mem_read"},  32'(mem_read),  32'(g & ~we));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(g & we));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(a));
    check({tag, ".mem_wdata"}, mem_wdata,      wd);
    check({tag, ".mem_func3"}, 32'(mem_func3), 32'(f3));
    if (g && we) ref_mem[int'(a)] = wd;
    if (g && !we && push) sb_q.push_back('{port: ed, data: exp_word(a)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_clr = 1'b1;
    reset   = 1'b1;
    set_cpu(1'b1, 1'b0, 9'h004, 32'h0, 3'b010);
    set_dbg(1'b1, 1'b0, 9'h008, 32'h0, 3'b010);

    // Reset: no grants, stall follows cpu_req, no memory access.
    cyc(1'b0, 1'b0, 1'b0, "rst0");
    mem_clr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, "rst1");
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "idle");
    check("starve_after_rst", 32'(dut.starve_q), 32'h0);

    // CPU alone reads 0x010.
    set_cpu(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    cyc(1'b1, 1'b0, 1'b1, "cpu_rd");
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "cpu_rd_ret");

    // Contention with STARVE_MAX=4: CPU x4, DBG, CPU.
    set_cpu(1'b1, 1'b0, 9'h030, 32'h0, 3'b010);
    set_dbg(1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    for (int i = 0; i < 6; i++) begin
      cyc(i != 4, i == 4, 1'b1, $sformatf("cont%0d", i));
      if (i == 4) check("starve_cleared", 32'(dut.starve_q), 32'h0);
    end
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "cont_end");

    // Alternating reads, one per cycle.
    set_cpu(1'b1, 1'b0, 9'h004, 32'h0, 3'b010);
    cyc(1'b1, 1'b0, 1'b1, "alt0");
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b1, 1'b0, 9'h008, 32'h0, 3'b010);
    cyc(1'b0, 1'b1, 1'b1, "alt1");
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "alt2");

    // Debug write, then CPU lw of the same word.
    set_dbg(1'b1, 1'b1, 9'h020, 32'h1234_5678, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, "wr");
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    set_cpu(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    cyc(1'b1, 1'b0, 1'b1, "wr_rd");
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "wr_rd_ret");

    // Both write the same word: only the CPU reaches memory, debug retries.
    set_cpu(1'b1, 1'b1, 9'h050, 32'h1111_1111, 3'b001);
    set_dbg(1'b1, 1'b1, 9'h050, 32'h2222_2222, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, "same0");
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, "same1");
    set_dbg(1'b1, 1'b0, 9'h050, 32'h0, 3'b010);
    cyc(1'b0, 1'b1, 1'b1, "same_rd");
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "same_ret");

    // Reset right after an accepted CPU read, with the counter part-way up.
    set_cpu(1'b1, 1'b0, 9'h060, 32'h0, 3'b010);
    set_dbg(1'b1, 1'b0, 9'h070, 32'h0, 3'b010);
    cyc(1'b1, 1'b0, 1'b1, "pre0");
    cyc(1'b1, 1'b0, 1'b1, "pre1");
    cyc(1'b1, 1'b0, 1'b0, "rdN");
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, "rst_mid");
    reset = 1'b0;
    check("starve_post_rst", 32'(dut.starve_q), 32'h0);
    for (int i = 0; i < 5; i++) cyc(i != 4, i == 4, 1'b1, $sformatf("post%0d", i));
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "post_end");

    // Debug withdraws for one cycle: the count restarts from zero.
    set_cpu(1'b1, 1'b0, 9'h080, 32'h0, 3'b010);
    set_dbg(1'b1, 1'b0, 9'h090, 32'h0, 3'b010);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, $sformatf("wd%0d", i));
    check("starve_three", 32'(dut.starve_q), 32'h3);
    dbg_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, "wd_low");
    check("starve_withdrawn", 32'(dut.starve_q), 32'h0);
    dbg_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc(i != 4, i == 4, 1'b1, $sformatf("wd_again%0d", i));
    set_cpu(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, "final");

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
